// File: rtl/pm_min_sched_pkg.sv
// Shared widths, FSM encoding and the modulo path-metric compare rule
// for the minimum-path-metric search sequencer.
package pm_min_sched_pkg;

  localparam int SM_W   = 8;   // path-metric width, MSB is the wrap bit
  localparam int IDX_W  = 6;   // global state index width (64 states)
  localparam int U      = 1;   // slice-select width
  localparam int N_LANE = 32;  // metrics per slice

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    SEL  = 3'd2,
    CAP  = 3'd3,
    DONE = 3'd4
  } state_t;

  // True when metric a is modulo-smaller than b; an exact tie returns 0 so
  // the later operand wins, matching the selector tree.
  function automatic logic pm_lt(input logic [SM_W-1:0] a, input logic [SM_W-1:0] b);
    return a[SM_W-1] ^ b[SM_W-1] ^ (a[SM_W-2:0] < b[SM_W-2:0]);
  endfunction

endpackage

// File: rtl/pm_min_sched_mod_cmp.sv
// pm_mod_cmp: combinational two-input modulo compare. Operand a is the
// running best, operand b the newer candidate; b wins ties.
module pm_mod_cmp
  import pm_min_sched_pkg::*;
(
  input  logic [SM_W-1:0]  a_value,
  input  logic [IDX_W-1:0] a_index,
  input  logic [SM_W-1:0]  b_value,
  input  logic [IDX_W-1:0] b_index,
  output logic [SM_W-1:0]  win_value,
  output logic [IDX_W-1:0] win_index
);

  logic keep_a;

  // Pick the modulo-smaller metric together with its state index.
  always_comb begin
    keep_a    = pm_lt(a_value, b_value);
    win_value = keep_a ? a_value : b_value;
    win_index = keep_a ? a_index : b_index;
  end

endmodule

// File: rtl/pm_min_sched.sv
// pm_min_sched: sequences the 32-way minimum selector tree over the PM
// slices, merges the per-slice minima with the modulo rule and reports
// the global best state. Optional macro PM_NORM_EN adds the metric
// normalisation hint outputs norm_vld / norm_value.
module pm_min_sched
  import pm_min_sched_pkg::*;
#(
  parameter int N_SLICE = 2,
  parameter int SEL_LAT = 1
`ifdef PM_NORM_EN
  ,
  parameter logic [SM_W-1:0] NORM_TH = 8'd64
`endif
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  output logic                     busy,
  output logic                     pm_rd_req,
  output logic [U-1:0]             pm_rd_slice,
  input  logic                     pm_rd_ack,
  input  logic [N_LANE*SM_W-1:0]   pm_rd_data,
  output logic                     sel_en,
  output logic [U-1:0]             sel_slice,
  output logic [N_LANE*SM_W-1:0]   sel_array,
  input  logic [IDX_W-1:0]         sel_index,
  input  logic [SM_W-1:0]          sel_value,
  output logic                     done,
  output logic [IDX_W-1:0]         best_index,
  output logic [SM_W-1:0]          best_value
`ifdef PM_NORM_EN
  ,
  output logic                     norm_vld,
  output logic [SM_W-1:0]          norm_value
`endif
);

  localparam logic [U-1:0] LAST_SLICE = U'(N_SLICE - 1);
  localparam logic [3:0]   LAT_LD     = 4'(SEL_LAT);

  state_t           state, state_nx;
  logic [U-1:0]     slice;
  logic [3:0]       wait_cnt;
  logic [SM_W-1:0]  run_value;
  logic [IDX_W-1:0] run_index;
  logic [SM_W-1:0]  mrg_value;
  logic [IDX_W-1:0] mrg_index;
  logic [SM_W-1:0]  cap_value;
  logic [IDX_W-1:0] cap_index;
  logic             rd_accept;

  pm_mod_cmp u_merge (
    .a_value   (run_value),
    .a_index   (run_index),
    .b_value   (sel_value),
    .b_index   (sel_index),
    .win_value (mrg_value),
    .win_index (mrg_index)
  );

  // Slice 0 seeds the running best; later slices go through the merge.
  always_comb begin
    cap_value = (slice == '0) ? sel_value : mrg_value;
    cap_index = (slice == '0) ? sel_index : mrg_index;
    rd_accept = (state == REQ) && (state_nx == SEL);
  end

  // Next-state and Moore outputs; abort overrides every non-idle transition.
  always_comb begin
    state_nx    = state;
    busy        = 1'b1;
    pm_rd_req   = 1'b0;
    pm_rd_slice = '0;
    sel_en      = 1'b0;
    sel_slice   = '0;
    done        = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start && !abort) state_nx = REQ;
      end
      REQ: begin
        pm_rd_req   = 1'b1;
        pm_rd_slice = slice;
        if (pm_rd_ack) state_nx = SEL;
      end
      SEL: begin
        sel_en    = 1'b1;
        sel_slice = slice;
        if (wait_cnt <= 4'd1) state_nx = CAP;
      end
      CAP: begin
        sel_en    = 1'b1;
        sel_slice = slice;
        state_nx  = (slice == LAST_SLICE) ? DONE : REQ;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (abort && (state != IDLE)) state_nx = IDLE;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Slice counter restarts whenever the search ends; wait counter times the tree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slice    <= '0;
      wait_cnt <= '0;
    end else begin
      if (state_nx == IDLE)                      slice <= '0;
      else if ((state == CAP) && (state_nx == REQ)) slice <= slice + U'(1);
      if (rd_accept)                             wait_cnt <= LAT_LD;
      else if ((state == SEL) && (wait_cnt != '0)) wait_cnt <= wait_cnt - 4'd1;
    end
  end

  // p0: slice data capture, held steady for the tree outside accept cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         sel_array <= '0;
    else if (rd_accept) sel_array <= pm_rd_data;
  end

  // p1: running best across slices, only meaningful inside a search.
  always_ff @(posedge clk) begin
    if (state == CAP) begin
      run_value <= cap_value;
      run_index <= cap_index;
    end
  end

  // p2: published result loads as the FSM enters DONE so it is valid with done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_value <= '0;
      best_index <= '0;
    end else if ((state == CAP) && (state_nx == DONE)) begin
      best_value <= cap_value;
      best_index <= cap_index;
    end
  end

`ifdef PM_NORM_EN
  // Normalisation hint on the wrap-stripped winning metric, DONE cycle only.
  always_comb begin
    norm_vld   = 1'b0;
    norm_value = '0;
    if (state == DONE) begin
      norm_vld   = ({1'b0, best_value[SM_W-2:0]} >= NORM_TH);
      norm_value = {1'b0, best_value[SM_W-2:0]};
    end
  end
`endif

endmodule

// File: tb/tb_pm_min_sched.sv
// Bench for pm_min_sched: two instances (SEL_LAT 1 and 2) share start/abort,
// each with its own PM-read responder, selector-tree model and a
// specification-level model that predicts done timing and results.
module tb_pm_min_sched;
  import pm_min_sched_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  int   ack_dly = 0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   t0 = 0;
  logic [32*SM_W-1:0] slice_data [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Modulo order: a is smaller when b sits 1..128 steps ahead of a.
  function automatic logic mod_lt(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] d;
    d = b - a;
    return (d >= 8'd1) && (d <= 8'd128);
  endfunction

  // Minimum of one slice, later entry wins ties; returns {index, metric}.
  function automatic logic [13:0] tree_min(input logic [255:0] arr, input int base);
    logic [7:0] v;
    logic [5:0] ix;
    v  = arr[7:0];
    ix = 6'(base);
    for (int i = 1; i < 32; i++) begin
      if (!mod_lt(v, arr[i*8 +: 8])) begin
        v  = arr[i*8 +: 8];
        ix = 6'(base + i);
      end
    end
    return {ix, v};
  endfunction

  function automatic logic [13:0] search_expect();
    logic [13:0] a, b;
    a = tree_min(slice_data[0], 0);
    b = tree_min(slice_data[1], 32);
    return mod_lt(a[7:0], b[7:0]) ? a : b;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic load_slice(input int s, input logic [7:0] mn, input int li);
    for (int i = 0; i < 32; i++)
      slice_data[s][i*8 +: 8] = (i == li) ? mn : 8'(mn + 8'd1 + 8'(i % 16));
  endtask

  task automatic run_search(input logic [7:0] m0, input int i0,
                            input logic [7:0] m1, input int i1);
    load_slice(0, m0, i0);
    load_slice(1, m1, i1);
    @(posedge clk); #1 start = 1'b1; t0 = cyc;
    @(posedge clk); #1 start = 1'b0;
  endtask

  for (genvar g = 0; g < 2; g++) begin : gi
    logic               busy, pm_rd_req, sel_en, done;
    logic               pm_rd_ack = 1'b0;
    logic [U-1:0]       pm_rd_slice, sel_slice;
    logic [32*SM_W-1:0] pm_rd_data = '0;
    logic [32*SM_W-1:0] sel_array;
    logic [IDX_W-1:0]   sel_index = '0;
    logic [IDX_W-1:0]   best_index;
    logic [SM_W-1:0]    sel_value = '0;
    logic [SM_W-1:0]    best_value;
`ifdef PM_NORM_EN
    logic               norm_vld;
    logic [SM_W-1:0]    norm_value;
    logic               last_nv = 1'b0;
    logic [SM_W-1:0]    last_nval = '0;
`endif
    int                 req_cnt = 0;
    int                 start_c = 0;
    int                 done_at = 0;
    int                 last_done = -1;
    bit                 pending = 1'b0;
    logic [13:0]        exp_new = '0;
    logic [13:0]        held = '0;

    pm_min_sched #(.N_SLICE(2), .SEL_LAT(g + 1)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .abort       (abort),
      .busy        (busy),
      .pm_rd_req   (pm_rd_req),
      .pm_rd_slice (pm_rd_slice),
      .pm_rd_ack   (pm_rd_ack),
      .pm_rd_data  (pm_rd_data),
      .sel_en      (sel_en),
      .sel_slice   (sel_slice),
      .sel_array   (sel_array),
      .sel_index   (sel_index),
      .sel_value   (sel_value),
      .done        (done),
      .best_index  (best_index),
      .best_value  (best_value)
`ifdef PM_NORM_EN
      ,
      .norm_vld    (norm_vld),
      .norm_value  (norm_value)
`endif
    );

    // PM storage: ack tied high when ack_dly is 0, else ack after ack_dly waits.
    always @(negedge clk) begin
      if (!rst_n || !pm_rd_req) begin
        req_cnt    = 0;
        pm_rd_ack  = (ack_dly == 0);
        pm_rd_data = slice_data[pm_rd_slice];
      end else if (req_cnt == ack_dly) begin
        pm_rd_ack  = 1'b1;
        pm_rd_data = slice_data[pm_rd_slice];
        req_cnt    = 0;
      end else begin
        pm_rd_ack = 1'b0;
        req_cnt++;
      end
    end

    // Selector tree: registers the slice minimum while enabled, holds otherwise.
    always @(posedge clk) begin
      if (sel_en) {sel_index, sel_value} <= tree_min(sel_array, 32 * int'(sel_slice));
    end

    // Model and per-cycle comparison.
    always @(negedge clk) begin
      bit          was_p, exp_done;
      logic [13:0] exp_now;
      if (!rst_n) begin
        pending = 1'b0;
        held    = '0;
      end else begin
        was_p    = pending;
        exp_done = pending && (cyc == done_at);
        exp_now  = exp_done ? exp_new : held;
        chk($sformatf("done[%0d]", g), done, exp_done);
        chk($sformatf("busy[%0d]", g), busy, pending && (cyc > start_c));
        chk($sformatf("best_index[%0d]", g), best_index, exp_now[13:8]);
        chk($sformatf("best_value[%0d]", g), best_value, exp_now[7:0]);
`ifdef PM_NORM_EN
        chk($sformatf("norm_vld[%0d]", g), norm_vld,
            exp_done && ({1'b0, exp_now[6:0]} >= 8'd64));
        chk($sformatf("norm_value[%0d]", g), norm_value,
            exp_done ? {1'b0, exp_now[6:0]} : 8'd0);
        if (done) begin
          last_nv   = norm_vld;
          last_nval = norm_value;
        end
`endif
        if (done) last_done = cyc;
        if (exp_done) begin
          held    = exp_new;
          pending = 1'b0;
        end else if (was_p && abort) begin
          pending = 1'b0;
        end
        if (!was_p && start && !abort) begin
          pending = 1'b1;
          start_c = cyc;
          done_at = cyc + 1 + 2 * (ack_dly + 3 + g);
          exp_new = search_expect();
        end
      end
    end
  end

  initial begin
    load_slice(0, 8'd200, 0);
    load_slice(1, 8'd200, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy0", gi[0].busy, 0);
    chk("rst done0", gi[0].done, 0);
    chk("rst pm_rd_req0", gi[0].pm_rd_req, 0);
    chk("rst sel_en0", gi[0].sel_en, 0);
    chk("rst sel_array0", (gi[0].sel_array == '0), 1);
    chk("rst best_index0", gi[0].best_index, 0);
    chk("rst best_value1", gi[1].best_value, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Basic search, ack tied high.
    run_search(8'd10, 5, 8'd20, 8);
    repeat (14) @(posedge clk); #1;
    chk("t1 latency0", gi[0].last_done - t0, 7);
    chk("t1 latency1", gi[1].last_done - t0, 9);
    chk("t1 best_index", gi[0].best_index, 5);
    chk("t1 best_value", gi[0].best_value, 10);

    // Wrap: 0x81 is modulo-larger than 0x7E.
    run_search(8'h7E, 3, 8'h81, 20);
    repeat (14) @(posedge clk); #1;
    chk("wrap best_value", gi[0].best_value, 8'h7E);
    chk("wrap best_index", gi[1].best_index, 3);

    // Tie across slices: later slice wins.
    run_search(8'd33, 12, 8'd33, 18);
    repeat (14) @(posedge clk); #1;
    chk("tie best_index0", gi[0].best_index, 50);
    chk("tie best_index1", gi[1].best_index, 50);

    // Delayed ack, with a start pulse mid-search that must be ignored.
    ack_dly = 3;
    run_search(8'd50, 7, 8'd45, 1);
    repeat (3) @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (25) @(posedge clk); #1;
    chk("dly latency1", gi[1].last_done - t0, 15);
    chk("dly latency0", gi[0].last_done - t0, 13);
    chk("dly best_index", gi[1].best_index, 33);
    chk("dly best_value", gi[1].best_value, 45);
    ack_dly = 0;
    repeat (2) @(posedge clk);

    // Abort in SEL of slice 1 (SEL_LAT=1 instance).
    run_search(8'd5, 0, 8'd3, 31);
    repeat (4) @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    chk("abort busy0", gi[0].busy, 0);
    chk("abort busy1", gi[1].busy, 0);
    repeat (14) @(posedge clk); #1;
    chk("abort no done", (gi[0].last_done < t0), 1);
    chk("abort held index", gi[0].best_index, 33);
    chk("abort held value", gi[0].best_value, 45);

    // Start together with abort in IDLE is dropped.
    @(posedge clk); #1 start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    chk("start+abort busy", gi[0].busy, 0);
    repeat (3) @(posedge clk);

    // New searches complete normally; metrics above and below NORM_TH.
    run_search(8'd70, 9, 8'd90, 9);
    repeat (14) @(posedge clk); #1;
    chk("n70 best_index", gi[0].best_index, 9);
    chk("n70 best_value", gi[0].best_value, 70);
`ifdef PM_NORM_EN
    chk("n70 norm_vld", gi[0].last_nv, 1);
    chk("n70 norm_value", gi[0].last_nval, 70);
`endif
    run_search(8'd30, 2, 8'd100, 28);
    repeat (14) @(posedge clk); #1;
    chk("n30 best_index", gi[1].best_index, 2);
    chk("n30 best_value", gi[1].best_value, 30);
`ifdef PM_NORM_EN
    chk("n30 norm_vld", gi[1].last_nv, 0);
`endif

    // Asynchronous reset mid-search returns everything to reset values.
    run_search(8'd11, 4, 8'd12, 6);
    repeat (2) @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("mid-rst busy", gi[0].busy, 0);
    chk("mid-rst sel_en", gi[1].sel_en, 0);
    chk("mid-rst best_value", gi[0].best_value, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
